// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 LCD controller and its display master.
package lcd_ctrl_pkg;

    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_EXEC} phase_e;

    localparam int N_INIT = 4;
    // Index 0 is issued first: function set, display on, entry mode, clear.
    localparam logic [N_INIT-1:0][7:0] INIT_SEQ = {8'h01, 8'h06, 8'h0C, 8'h38};

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] CLEAR_DISPLAY = 8'h01;
    localparam logic [7:0] RETURN_HOME   = 8'h02;

    // 0x03 is also Return Home on the HD44780 (DB0 is don't-care).
    function automatic logic needs_long_exec(input logic [7:0] instr);
        return (instr == CLEAR_DISPLAY) || ((instr & 8'hFE) == RETURN_HOME);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One timed HD44780 bus cycle (setup, enable pulse, hold, execution wait).
// Comes out of reset already busy in EXEC so the same counter times the power-up wait.
module lcd_bus_cycle
    import lcd_ctrl_pkg::*;
#(
    parameter int T_SETUP   = 4,
    parameter int T_PULSE   = 16,
    parameter int T_HOLD    = 4,
    parameter int T_SHORT   = 2000,
    parameter int T_LONG    = 82000,
    parameter int T_POWERUP = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] data,
    input  logic       long_exec,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_PULSE), max_int(T_HOLD, T_SHORT)),
                                   max_int(T_LONG, T_POWERUP));
    localparam int CNT_W = $clog2(T_MAX) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    logic       busy_q, busy_d;
    phase_e     phase_q, phase_d;
    cnt_t       cnt_q, cnt_d;
    logic       rs_q, rs_d, rw_q, rw_d, long_q, long_d, oe_q, oe_d;
    logic [7:0] data_q, data_d, rdata_q, rdata_d;

    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        long_d  = long_q;
        oe_d    = oe_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        done    = 1'b0;
        if (!busy_q) begin
            if (start) begin
                busy_d  = 1'b1;
                phase_d = PH_SETUP;
                cnt_d   = cnt_t'(T_SETUP - 1);
                rs_d    = rs;
                rw_d    = rw;
                long_d  = long_exec;
                oe_d    = ~rw;
                data_d  = data;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - cnt_t'(1);
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_PULSE;
                    cnt_d   = cnt_t'(T_PULSE - 1);
                end
                PH_PULSE: begin
                    phase_d = PH_HOLD;
                    cnt_d   = cnt_t'(T_HOLD - 1);
                    if (rw_q) rdata_d = lcd_data_in;
                end
                PH_HOLD: begin
                    if (rw_q) begin
                        done   = 1'b1;
                        busy_d = 1'b0;
                        oe_d   = 1'b0;
                    end else begin
                        phase_d = PH_EXEC;
                        cnt_d   = long_q ? cnt_t'(T_LONG - 1) : cnt_t'(T_SHORT - 1);
                    end
                end
                default: begin
                    done   = 1'b1;
                    busy_d = 1'b0;
                    oe_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b1;
            phase_q <= PH_EXEC;
            cnt_q   <= cnt_t'(T_POWERUP - 1);
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            long_q  <= 1'b0;
            oe_q    <= 1'b0;
            data_q  <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            long_q  <= long_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy         = busy_q;
    assign rdata        = rdata_q;
    assign lcd_data_out = data_q;
    assign lcd_data_oe  = oe_q;
    assign lcd_rs       = rs_q;
    assign lcd_rw       = rw_q;
    assign lcd_en       = busy_q && (phase_q == PH_PULSE);

endmodule

// File: rtl/lcd_avalon_controller.sv
// Avalon-MM slave front end for an HD44780 16x2 LCD: power-up init, then one
// LCD bus cycle per accepted transfer, stretched with waitrequest until it completes.
//
//   state   | meaning
//   POWERUP | waiting T_POWERUP after reset (timed inside the bus cycle unit)
//   INIT    | issuing INIT_SEQ, one bus cycle per entry
//   IDLE    | ready for an Avalon transfer
//   BUSY    | LCD bus cycle of the accepted transfer in progress
//   ACK     | single completing cycle, waitrequest low
module lcd_avalon_controller
    import lcd_ctrl_pkg::*;
#(
    parameter int T_SETUP   = 4,
    parameter int T_PULSE   = 16,
    parameter int T_HOLD    = 4,
    parameter int T_SHORT   = 2000,
    parameter int T_LONG    = 82000,
    parameter int T_POWERUP = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       address,
    input  logic       chipselect,
    input  logic       byteenable,
    input  logic       read,
    input  logic       write,
    output logic       waitrequest,
    output logic [7:0] readdata,
    output logic [1:0] response,
    input  logic [7:0] writedata,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_BUSY    = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam int IDX_W = $clog2(N_INIT);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]       resp_q, resp_d;
    logic [7:0]       readdata_q, readdata_d;

    logic       req, bus_start, bus_rs, bus_rw, bus_long, bus_busy, bus_done;
    logic [7:0] bus_data, bus_rdata;

    assign req = chipselect & (write | read);

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        resp_d     = resp_q;
        readdata_d = readdata_q;
        bus_start  = 1'b0;
        bus_rs     = address;
        bus_rw     = read & ~write;
        bus_data   = writedata;
        bus_long   = ~address & ~(read & ~write) & needs_long_exec(writedata);
        case (state_q)
            ST_POWERUP: begin
                if (bus_done) begin
                    state_d    = ST_INIT;
                    init_idx_d = '0;
                end
            end
            ST_INIT: begin
                bus_rs    = 1'b0;
                bus_rw    = 1'b0;
                bus_data  = INIT_SEQ[init_idx_q];
                bus_long  = needs_long_exec(INIT_SEQ[init_idx_q]);
                bus_start = ~bus_busy;
                if (bus_done) begin
                    if (init_idx_q == IDX_W'(N_INIT - 1)) state_d = ST_IDLE;
                    else init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (req) begin
                    if (!byteenable) begin
                        resp_d  = RESP_SLVERR;
                        state_d = ST_ACK;
                    end else begin
                        bus_start = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (bus_done) begin
                    resp_d  = RESP_OKAY;
                    state_d = ST_ACK;
                    if (lcd_rw) readdata_d = bus_rdata;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_POWERUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_POWERUP;
            init_idx_q <= '0;
            resp_q     <= RESP_OKAY;
            readdata_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            resp_q     <= resp_d;
            readdata_q <= readdata_d;
        end
    end

    lcd_bus_cycle #(
        .T_SETUP  (T_SETUP),
        .T_PULSE  (T_PULSE),
        .T_HOLD   (T_HOLD),
        .T_SHORT  (T_SHORT),
        .T_LONG   (T_LONG),
        .T_POWERUP(T_POWERUP)
    ) u_bus (
        .clk         (clk),
        .reset       (reset),
        .start       (bus_start),
        .rs          (bus_rs),
        .rw          (bus_rw),
        .data        (bus_data),
        .long_exec   (bus_long),
        .busy        (bus_busy),
        .done        (bus_done),
        .rdata       (bus_rdata),
        .lcd_data_out(lcd_data_out),
        .lcd_data_oe (lcd_data_oe),
        .lcd_data_in (lcd_data_in),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en)
    );

    assign waitrequest = (state_q != ST_ACK);
    assign readdata    = readdata_q;
    assign response    = resp_q;

endmodule

// File: tb/tb_lcd_avalon_controller.sv
// Bench for lcd_avalon_controller: LCD bus cycles are scoreboarded against expectations
// queued when each transfer is driven; Avalon latency/response/readdata checked per task.
module tb_lcd_avalon_controller;

    localparam int T_SETUP   = 2;
    localparam int T_PULSE   = 4;
    localparam int T_HOLD    = 2;
    localparam int T_SHORT   = 10;
    localparam int T_LONG    = 50;
    localparam int T_POWERUP = 100;
    localparam int LAT_SHORT = T_SETUP + T_PULSE + T_HOLD + T_SHORT;
    localparam int LAT_LONG  = T_SETUP + T_PULSE + T_HOLD + T_LONG;
    localparam int LAT_READ  = T_SETUP + T_PULSE + T_HOLD;

    logic       clk, reset, address, chipselect, byteenable, read, write;
    logic       waitrequest, lcd_data_oe, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] readdata, writedata, lcd_data_out, lcd_data_in, rd_val;
    logic [1:0] response;

    int errors = 0;
    int checks = 0;
    logic cut_ok = 1'b0;
    logic [10:0] exp_q[$];

    // LCD drives the read value only while enabled, so a late capture is visible.
    assign lcd_data_in = lcd_en ? rd_val : 8'h11;

    lcd_avalon_controller #(
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_SHORT(T_SHORT), .T_LONG(T_LONG), .T_POWERUP(T_POWERUP)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .byteenable(byteenable), .read(read), .write(write), .waitrequest(waitrequest),
        .readdata(readdata), .response(response), .writedata(writedata),
        .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe), .lcd_data_in(lcd_data_in),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: pops the expected {rs, rw, oe, data} at each enable rise.
    initial begin
        logic        en_prev;
        logic [10:0] snap, exp_v;
        int          width;
        en_prev = 1'b0;
        width   = 0;
        snap    = '0;
        forever begin
            @(negedge clk);
            checks++;
            if (lcd_data_oe && lcd_rw) begin
                errors++;
                $display("FAIL oe_while_read: oe=%b rw=%b required not both 1", lcd_data_oe, lcd_rw);
            end
            if (lcd_en && !en_prev) begin
                snap  = {lcd_rs, lcd_rw, lcd_data_oe, lcd_data_out};
                width = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got %h, required no pulse", snap);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (snap !== exp_v) begin
                        errors++;
                        $display("FAIL bus_cycle: got {rs,rw,oe,data}=%h required %h", snap, exp_v);
                    end
                end
            end else if (lcd_en) begin
                width++;
                checks++;
                if ({lcd_rs, lcd_rw, lcd_data_oe, lcd_data_out} !== snap) begin
                    errors++;
                    $display("FAIL bus_stable: got %h required %h",
                             {lcd_rs, lcd_rw, lcd_data_oe, lcd_data_out}, snap);
                end
            end else if (en_prev && !cut_ok) begin
                checks++;
                if (width != T_PULSE) begin
                    errors++;
                    $display("FAIL en_width: got %0d required %0d", width, T_PULSE);
                end
            end
            en_prev = lcd_en;
        end
    end

    task automatic push_init();
        exp_q.push_back({3'b001, 8'h38});
        exp_q.push_back({3'b001, 8'h0C});
        exp_q.push_back({3'b001, 8'h06});
        exp_q.push_back({3'b001, 8'h01});
    endtask

    // Drives a transfer at the current negedge and waits for ACK; leaves it asserted.
    task automatic xfer(input logic a, input logic rd, input logic wr, input logic be,
                        input logic [7:0] wd, output int lat, output logic [7:0] rdat,
                        output logic [1:0] rsp);
        logic rw_e;
        rw_e       = rd & ~wr;
        chipselect = 1'b1;
        address    = a;
        read       = rd;
        write      = wr;
        byteenable = be;
        writedata  = wd;
        if (be) exp_q.push_back({a, rw_e, ~rw_e, wd});
        lat  = -1;
        rdat = 8'hxx;
        rsp  = 2'bxx;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (!waitrequest) begin
                lat  = n - 1;
                rdat = readdata;
                rsp  = response;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: no ACK within 400 cycles, required ACK");
        end
    endtask

    task automatic end_xfer();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        @(negedge clk);
        checks++;
        if (waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL ack_one_cycle: waitrequest=%b required 1", waitrequest);
        end
    endtask

    task automatic wait_falls(input int nfalls, output int cycles);
        logic prev;
        int   falls;
        prev   = lcd_en;
        falls  = 0;
        cycles = 0;
        while (falls < nfalls && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (prev && !lcd_en) falls++;
            prev = lcd_en;
            checks++;
            if (waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL init_wait: waitrequest=%b required 1", waitrequest);
            end
        end
        checks++;
        if (falls != nfalls) begin
            errors++;
            $display("FAIL init_pulses: got %0d pulses required %0d", falls, nfalls);
        end
    endtask

    task automatic test_reset();
        int n, cyc, lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({waitrequest, lcd_en, lcd_rs, lcd_rw, lcd_data_oe} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: {wr,en,rs,rw,oe}=%b required 10000",
                     {waitrequest, lcd_en, lcd_rs, lcd_rw, lcd_data_oe});
        end
        checks++;
        if ({lcd_data_out, readdata, response} !== 18'h0) begin
            errors++;
            $display("FAIL reset_data: {data,readdata,resp}=%h required 0",
                     {lcd_data_out, readdata, response});
        end
        push_init();
        reset = 1'b1;
        n = 0;
        while (!lcd_en && n < 1000) begin
            @(negedge clk);
            n++;
            checks++;
            if (waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL powerup_wait: waitrequest=%b required 1", waitrequest);
            end
        end
        checks++;
        if (n < T_POWERUP + T_SETUP || n > T_POWERUP + T_SETUP + 2) begin
            errors++;
            $display("FAIL first_pulse: at cycle %0d required %0d..%0d", n,
                     T_POWERUP + T_SETUP, T_POWERUP + T_SETUP + 2);
        end
        wait_falls(4, cyc);
        // Issued as the clear pulse ends: must wait out hold + long exec first.
        xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'h48, lat, rdat, rsp);
        checks++;
        if (lat != T_HOLD + T_LONG + LAT_SHORT) begin
            errors++;
            $display("FAIL queued_during_init: latency %0d required %0d", lat,
                     T_HOLD + T_LONG + LAT_SHORT);
        end
        end_xfer();
    endtask

    task automatic test_write_data();
        int lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'h41, lat, rdat, rsp);
        checks++;
        if (lat != LAT_SHORT) begin
            errors++;
            $display("FAIL write_data_lat: got %0d required %0d", lat, LAT_SHORT);
        end
        checks++;
        if (rsp !== 2'b00) begin
            errors++;
            $display("FAIL write_data_resp: got %b required 00", rsp);
        end
        end_xfer();
    endtask

    task automatic test_exec_table();
        logic       t_addr[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] t_data[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01};
        int         t_lat[6]  = '{LAT_LONG, LAT_LONG, LAT_LONG, LAT_SHORT, LAT_SHORT, LAT_SHORT};
        int lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        for (int i = 0; i < 6; i++) begin
            xfer(t_addr[i], 1'b0, 1'b1, 1'b1, t_data[i], lat, rdat, rsp);
            checks++;
            if (lat != t_lat[i] || rsp !== 2'b00) begin
                errors++;
                $display("FAIL exec_len[%0d]: addr=%b data=%h latency %0d resp %b required %0d resp 00",
                         i, t_addr[i], t_data[i], lat, rsp, t_lat[i]);
            end
            end_xfer();
        end
    endtask

    task automatic test_read();
        logic       t_addr[2] = '{1'b0, 1'b1};
        logic [7:0] t_val[2]  = '{8'h80, 8'h5A};
        int lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        for (int i = 0; i < 2; i++) begin
            rd_val = t_val[i];
            xfer(t_addr[i], 1'b1, 1'b0, 1'b1, 8'h00, lat, rdat, rsp);
            checks++;
            if (lat != LAT_READ) begin
                errors++;
                $display("FAIL read_lat[%0d]: got %0d required %0d", i, lat, LAT_READ);
            end
            checks++;
            if (rdat !== t_val[i] || rsp !== 2'b00) begin
                errors++;
                $display("FAIL read_data[%0d]: got %h resp %b required %h resp 00",
                         i, rdat, rsp, t_val[i]);
            end
            end_xfer();
        end
    endtask

    task automatic test_byteenable_zero();
        int lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        for (int i = 0; i < 2; i++) begin
            xfer(1'b1, i[0], ~i[0], 1'b0, 8'h33, lat, rdat, rsp);
            checks++;
            if (lat != 0 || rsp !== 2'b10) begin
                errors++;
                $display("FAIL be0[%0d]: latency %0d resp %b required 0 resp 10", i, lat, rsp);
            end
            checks++;
            if (rdat !== 8'h5A) begin
                errors++;
                $display("FAIL be0_readdata[%0d]: got %h required 5a", i, rdat);
            end
            end_xfer();
        end
    endtask

    task automatic test_write_read_both();
        int lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        xfer(1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, lat, rdat, rsp);
        checks++;
        if (lat != LAT_SHORT || rsp !== 2'b00) begin
            errors++;
            $display("FAIL write_and_read: latency %0d resp %b required %0d resp 00",
                     lat, rsp, LAT_SHORT);
        end
        end_xfer();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, lat, rdat, rsp);
        checks++;
        if (lat != LAT_SHORT) begin
            errors++;
            $display("FAIL b2b_first: latency %0d required %0d", lat, LAT_SHORT);
        end
        // Next request is presented during ACK; it is sampled in the IDLE cycle after.
        xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, lat, rdat, rsp);
        checks++;
        if (lat != LAT_SHORT + 1) begin
            errors++;
            $display("FAIL b2b_second: latency %0d required %0d", lat, LAT_SHORT + 1);
        end
        end_xfer();
    endtask

    task automatic test_reset_mid_pulse();
        int n, cyc, lat;
        logic [7:0] rdat;
        logic [1:0] rsp;
        chipselect = 1'b1;
        address    = 1'b1;
        read       = 1'b0;
        write      = 1'b1;
        byteenable = 1'b1;
        writedata  = 8'h55;
        exp_q.push_back({3'b101, 8'h55});
        n = 0;
        while (!lcd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cut_ok     = 1'b1;
        reset      = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        #1;
        checks++;
        if (lcd_en !== 1'b0 || waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pulse: en=%b waitrequest=%b required en=0 waitrequest=1",
                     lcd_en, waitrequest);
        end
        repeat (2) @(negedge clk);
        cut_ok = 1'b0;
        push_init();
        reset = 1'b1;
        for (int i = 0; i < T_POWERUP; i++) begin
            @(negedge clk);
            checks++;
            if (waitrequest !== 1'b1 || lcd_en !== 1'b0) begin
                errors++;
                $display("FAIL powerup_rerun: waitrequest=%b en=%b required 1 and 0",
                         waitrequest, lcd_en);
            end
        end
        wait_falls(4, cyc);
        repeat (T_HOLD + T_LONG + 2) @(negedge clk);
        xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'h42, lat, rdat, rsp);
        checks++;
        if (lat != LAT_SHORT) begin
            errors++;
            $display("FAIL after_reinit: latency %0d required %0d", lat, LAT_SHORT);
        end
        end_xfer();
    endtask

    initial begin
        reset      = 1'b0;
        address    = 1'b0;
        chipselect = 1'b0;
        byteenable = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 8'h00;
        rd_val     = 8'h00;
        @(negedge clk);
        test_reset();
        test_write_data();
        test_exec_table();
        test_read();
        test_byteenable_zero();
        test_write_read_both();
        test_back_to_back();
        test_reset_mid_pulse();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d expected bus cycles never seen, required 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
